id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage of the 5-stage CPU. It registers decoded operands and control from ID and forwards EX/MEM and MEM/WB results into the operands. It drives the ALU's two 32-bit operands and its 3-bit control directly. It also detects load-use hazards, inserts bubbles and signals upstream to hold PC and IF/ID.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs_addr_i, id_rt_addr_i  in  5  source register numbers
- id_rs_data_i, id_rt_data_i  in  32  register-file read data
- id_imm_i  in  32  sign-extended immediate
- id_alusrc_i  in  1  1 = operand 2 is the immediate
- id_aluctrl_i  in  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 100 mul
- id_rd_addr_i  in  5  destination register, already resolved from rt or rd
- id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i  in  1  control bits
- flush_i  in  1  taken branch; discard the ID instruction
- exmem_rd_addr_i  in  5  EX/MEM destination register
- exmem_regwrite_i  in  1  EX/MEM write enable
- exmem_result_i  in  32  EX/MEM ALU result
- memwb_rd_addr_i  in  5  MEM/WB destination register
- memwb_regwrite_i  in  1  MEM/WB write enable
- memwb_result_i  in  32  MEM/WB writeback data
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid_o  out  1  EX holds a real instruction
- ex_data1_o, ex_data2_o  out  32  ALU operands
- ex_aluctrl_o  out  3  ALU op
- ex_store_data_o  out  32  forwarded rt value, for stores
- ex_rd_addr_o  out  5  destination register
- ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o  out  1  control bits

## Operation
- Registered fields: valid, rs/rt addresses, rs/rt data, imm, alusrc, aluctrl, rd, and the four control bits. Reset clears all of them to 0.
- Each rising edge loads exactly one of the following, in priority order:
  - Bubble, if flush_i, stall_o or !id_valid_i is high. A bubble sets every field to 0, so valid = 0 and all control bits = 0.
  - Otherwise, the ID inputs.
- Forwarding applies to rs and rt independently; operand rs is shown:
  - Use exmem_result_i if exmem_regwrite_i is high, exmem_rd_addr_i != 0 and exmem_rd_addr_i == rs_q.
  - Else use memwb_result_i if memwb_regwrite_i is high, memwb_rd_addr_i != 0 and memwb_rd_addr_i == rs_q.
  - Else use rs_data_q.
  - Register 0 is never forwarded.
- Operand outputs:
  - ex_data1_o = forwarded rs.
  - ex_store_data_o = forwarded rt.
  - ex_data2_o = alusrc_q ? imm_q : forwarded rt.
- Load-use stall, raised when all of the following hold:
  - id_valid_i is high and flush_i is low;
  - valid_q and memread_q are high;
  - rd_q != 0;
  - rd_q == id_rs_addr_i or rd_q == id_rt_addr_i. Both sources are always compared, which is conservative.
- A stall inserts one bubble. The next cycle re-evaluates with the load now in EX/MEM, so no stall arises from it; its loaded value reaches the operand through MEM/WB forwarding one cycle later.
- Simultaneous events: flush_i wins over stall. It forces stall_o = 0 and loads a bubble.
- stall_o is forced to 0 while rst_i is low.

## Timing
- Capture latency is 1 cycle: values on the ID inputs at edge N appear on the ex_* outputs after edge N.
- Forwarding is combinational, from the exmem/memwb inputs to ex_data*/ex_store_data_o in the same cycle.
- stall_o is combinational from the ID inputs and registered state, valid in the same cycle.
- Reset values:
  - stall_o = 0.
  - All ex_* outputs = 0, because forwarding excludes register 0.
- Reset asserted mid-operation clears the in-flight instruction immediately, asynchronously.

## Configuration
- OPERAND_FWD_EN defined:
  - Forwarding as above.
  - Only load-use stalls.
- OPERAND_FWD_EN undefined:
  - No forwarding; outputs use the registered register-file data.
  - stall_o rises on any nonzero ID source match against:
    - EX (regwrite_q, valid_q),
    - EX/MEM (exmem_regwrite_i),
    - MEM/WB (memwb_regwrite_i).
  - A dependent instruction therefore stalls up to 3 cycles.
  - Flush priority and bubble format are unchanged.

## Test plan
- Reset: hold rst_i low with random inputs → all outputs 0 and stall_o 0. Release it and load add r3=r1+r2 with data 5 and 7 → next cycle ex_data1_o=5, ex_data2_o=7, ex_aluctrl_o=010.
- EX/MEM forwarding: exmem rd=3, regwrite=1, result=0x10 while EX has rs=3 → ex_data1_o=0x10. Also drive memwb rd=3 with result 0x20 → ex_data1_o still 0x10, because EX/MEM has priority.
- Register 0: exmem rd=0, regwrite=1, result=0xFF with rs=0 → ex_data1_o=0.
- Load-use: lw r4 in EX, then ID sub using rt=r4 → stall_o=1 for exactly one cycle and one bubble (ex_valid_o=0). The sub then enters EX with memwb forwarding of the load data (0xABCD) on ex_data2_o.
- Flush during stall: the load-use condition and flush_i=1 in the same cycle → stall_o=0 and a bubble next cycle.
- OPERAND_FWD_EN undefined: add r5, then dependent or r6=r5|r1 → stall_o high for 3 cycles; the or then issues with register-file data.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side operands and control, forwarding sources from
// EX/MEM and MEM/WB, and the EX-side outputs feeding the ALU and memory stages.
interface id_ex_stage_if;
   logic        id_valid_i;
   logic [4:0]  id_rs_addr_i;
   logic [4:0]  id_rt_addr_i;
   logic [31:0] id_rs_data_i;
   logic [31:0] id_rt_data_i;
   logic [31:0] id_imm_i;
   logic        id_alusrc_i;
   logic [2:0]  id_aluctrl_i;
   logic [4:0]  id_rd_addr_i;
   logic        id_regwrite_i;
   logic        id_memread_i;
   logic        id_memwrite_i;
   logic        id_memtoreg_i;
   logic        flush_i;
   logic [4:0]  exmem_rd_addr_i;
   logic        exmem_regwrite_i;
   logic [31:0] exmem_result_i;
   logic [4:0]  memwb_rd_addr_i;
   logic        memwb_regwrite_i;
   logic [31:0] memwb_result_i;
   logic        stall_o;
   logic        ex_valid_o;
   logic [31:0] ex_data1_o;
   logic [31:0] ex_data2_o;
   logic [2:0]  ex_aluctrl_o;
   logic [31:0] ex_store_data_o;
   logic [4:0]  ex_rd_addr_o;
   logic        ex_regwrite_o;
   logic        ex_memread_o;
   logic        ex_memwrite_o;
   logic        ex_memtoreg_o;

   modport master (
      output id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rs_data_i, id_rt_data_i,
             id_imm_i, id_alusrc_i, id_aluctrl_i, id_rd_addr_i, id_regwrite_i,
             id_memread_i, id_memwrite_i, id_memtoreg_i, flush_i,
             exmem_rd_addr_i, exmem_regwrite_i, exmem_result_i,
             memwb_rd_addr_i, memwb_regwrite_i, memwb_result_i,
      input  stall_o, ex_valid_o, ex_data1_o, ex_data2_o, ex_aluctrl_o,
             ex_store_data_o, ex_rd_addr_o, ex_regwrite_o, ex_memread_o,
             ex_memwrite_o, ex_memtoreg_o
   );

   modport slave (
      input  id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rs_data_i, id_rt_data_i,
             id_imm_i, id_alusrc_i, id_aluctrl_i, id_rd_addr_i, id_regwrite_i,
             id_memread_i, id_memwrite_i, id_memtoreg_i, flush_i,
             exmem_rd_addr_i, exmem_regwrite_i, exmem_result_i,
             memwb_rd_addr_i, memwb_regwrite_i, memwb_result_i,
      output stall_o, ex_valid_o, ex_data1_o, ex_data2_o, ex_aluctrl_o,
             ex_store_data_o, ex_rd_addr_o, ex_regwrite_o, ex_memread_o,
             ex_memwrite_o, ex_memtoreg_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard stalls.
// OPERAND_FWD_EN enables EX/MEM and MEM/WB forwarding (load-use stalls only);
// without it every in-flight source dependency stalls until writeback.
module id_ex_stage (
   input  logic          clk_i,
   input  logic          rst_i,
   id_ex_stage_if.slave  bus
);

   logic        valid_q;
   logic [4:0]  rs_addr_q;
   logic [4:0]  rt_addr_q;
   logic [31:0] rs_data_q;
   logic [31:0] rt_data_q;
   logic [31:0] imm_q;
   logic        alusrc_q;
   logic [2:0]  aluctrl_q;
   logic [4:0]  rd_q;
   logic        regwrite_q;
   logic        memread_q;
   logic        memwrite_q;
   logic        memtoreg_q;

   logic        hazard;
   logic        stall;
   logic        bubble;
   logic [31:0] rs_fwd;
   logic [31:0] rt_fwd;

   function automatic logic src_match(input logic en, input logic [4:0] dst,
                                      input logic [4:0] rs, input logic [4:0] rt);
      return en && (dst != 5'd0) && ((dst == rs) || (dst == rt));
   endfunction

`ifdef OPERAND_FWD_EN
   // The younger producer (EX/MEM) wins; register 0 is hardwired and never forwarded.
   function automatic logic [31:0] fwd_sel(input logic [4:0] src, input logic [31:0] rf_data,
                                           input logic em_we, input logic [4:0] em_rd,
                                           input logic [31:0] em_res, input logic mw_we,
                                           input logic [4:0] mw_rd, input logic [31:0] mw_res);
      if (em_we && (em_rd != 5'd0) && (em_rd == src))
         return em_res;
      else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src))
         return mw_res;
      else
         return rf_data;
   endfunction

   always_comb begin
      rs_fwd = fwd_sel(rs_addr_q, rs_data_q, bus.exmem_regwrite_i, bus.exmem_rd_addr_i,
                       bus.exmem_result_i, bus.memwb_regwrite_i, bus.memwb_rd_addr_i,
                       bus.memwb_result_i);
      rt_fwd = fwd_sel(rt_addr_q, rt_data_q, bus.exmem_regwrite_i, bus.exmem_rd_addr_i,
                       bus.exmem_result_i, bus.memwb_regwrite_i, bus.memwb_rd_addr_i,
                       bus.memwb_result_i);
      hazard = src_match(valid_q && memread_q, rd_q, bus.id_rs_addr_i, bus.id_rt_addr_i);
   end
`else
   always_comb begin
      rs_fwd = rs_data_q;
      rt_fwd = rt_data_q;
      hazard = src_match(valid_q && regwrite_q, rd_q, bus.id_rs_addr_i, bus.id_rt_addr_i)
             | src_match(bus.exmem_regwrite_i, bus.exmem_rd_addr_i,
                         bus.id_rs_addr_i, bus.id_rt_addr_i)
             | src_match(bus.memwb_regwrite_i, bus.memwb_rd_addr_i,
                         bus.id_rs_addr_i, bus.id_rt_addr_i);
   end
`endif

   assign stall  = rst_i && bus.id_valid_i && !bus.flush_i && hazard;
   assign bubble = bus.flush_i || stall || !bus.id_valid_i;

   // A bubble zeroes every field, so downstream sees no valid or control bit.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i || bubble) begin
         valid_q    <= 1'b0;
         rs_addr_q  <= 5'd0;
         rt_addr_q  <= 5'd0;
         rs_data_q  <= 32'd0;
         rt_data_q  <= 32'd0;
         imm_q      <= 32'd0;
         alusrc_q   <= 1'b0;
         aluctrl_q  <= 3'd0;
         rd_q       <= 5'd0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
      end else begin
         valid_q    <= 1'b1;
         rs_addr_q  <= bus.id_rs_addr_i;
         rt_addr_q  <= bus.id_rt_addr_i;
         rs_data_q  <= bus.id_rs_data_i;
         rt_data_q  <= bus.id_rt_data_i;
         imm_q      <= bus.id_imm_i;
         alusrc_q   <= bus.id_alusrc_i;
         aluctrl_q  <= bus.id_aluctrl_i;
         rd_q       <= bus.id_rd_addr_i;
         regwrite_q <= bus.id_regwrite_i;
         memread_q  <= bus.id_memread_i;
         memwrite_q <= bus.id_memwrite_i;
         memtoreg_q <= bus.id_memtoreg_i;
      end
   end

   assign bus.stall_o         = stall;
   assign bus.ex_valid_o      = valid_q;
   assign bus.ex_data1_o      = rs_fwd;
   assign bus.ex_data2_o      = alusrc_q ? imm_q : rt_fwd;
   assign bus.ex_aluctrl_o    = aluctrl_q;
   assign bus.ex_store_data_o = rt_fwd;
   assign bus.ex_rd_addr_o    = rd_q;
   assign bus.ex_regwrite_o   = regwrite_q;
   assign bus.ex_memread_o    = memread_q;
   assign bus.ex_memwrite_o   = memwrite_q;
   assign bus.ex_memtoreg_o   = memtoreg_q;

endmodule
